// File: rtl/v_mul_pkg.sv
// Shared types, SEW encodings and defaults for the vector multiply controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package v_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [2:0] SEW8  = 3'b000;
  localparam logic [2:0] SEW16 = 3'b001;
  localparam logic [2:0] SEW32 = 3'b010;

  localparam int MUL_LAT_DEF = 4;
  localparam int MAX_VL_DEF  = 32;

  // Words touched by vl elements of (8 << sh) bits. 8 bits hold 32 << 2 plus
  // the round-up term, so nothing is truncated.
  function automatic logic [7:0] word_count(input logic [7:0] vl8, input logic [1:0] sh);
    logic [7:0] nbytes;
    nbytes = vl8 << sh;
    return (nbytes + 8'd3) >> 2;
  endfunction

  function automatic logic sew_legal(input logic [2:0] sew);
    return sew <= SEW32;
  endfunction

endpackage

// File: rtl/v_mul_ctrl_pipe.sv
// In-flight tracker: shifts {valid, word index} alongside the multiplier.
// Latency: MUL_LAT cycles from in_vld_i to out_vld_o.
// Backpressure: none; one entry may enter per cycle and the line never stalls.
module v_mul_ctrl_pipe #(
  parameter int MUL_LAT = 4,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_vld_i,
  input  logic [AW-1:0] in_idx_i,
  output logic          out_vld_o,
  output logic [AW-1:0] out_idx_o
);

  logic [MUL_LAT-1:0] vld_q;
  logic [AW-1:0]      idx_q [MUL_LAT];

  // Shift line; a reset drops every in-flight word so no stale write escapes.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) idx_q[k] <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      idx_q[0] <= in_idx_i;
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign out_vld_o = vld_q[MUL_LAT-1];
  assign out_idx_o = idx_q[MUL_LAT-1];

endmodule

// File: rtl/v_mul_ctrl.sv
// Vector multiply sequencer: reads N operand words, feeds an external multiplier, writes results.
// Latency: word i written 1+MUL_LAT cycles after its read; done one cycle after the last write.
// Backpressure: none; reads issue back to back and start is ignored while busy. Macro VMUL_CTRL_MASK_EN adds the mask port.
module v_mul_ctrl
  import v_mul_pkg::*;
#(
  parameter int  MUL_LAT = MUL_LAT_DEF,
  parameter int  MAX_VL  = MAX_VL_DEF,
  localparam int AW      = $clog2(MAX_VL)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [AW:0]   vl,
  input  logic [2:0]    sew,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data_a,
  input  logic [31:0]   rd_data_b,
  output logic [31:0]   mul_op_a,
  output logic [31:0]   mul_op_b,
  output logic [2:0]    mul_sew,
  output logic          mul_is_mul,
  input  logic [31:0]   mul_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    wr_be,
  output logic [31:0]   wr_data,
`ifdef VMUL_CTRL_MASK_EN
  input  logic [31:0]   mask,
`endif
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    n_q, n_d;
  logic [AW:0]   vl_q, vl_d;
  logic [2:0]    sew_q, sew_d;
  logic          err_q, err_d;
  logic          op_vld_q;
  logic [AW-1:0] op_idx_q;
`ifdef VMUL_CTRL_MASK_EN
  logic [31:0]   mask_q, mask_d;
`endif

  logic          pipe_vld;
  logic [AW-1:0] pipe_idx;
  logic [3:0]    be_raw;
  logic [AW+1:0] byte_pos;
  logic [AW+1:0] elem;
  logic [AW+1:0] vl_ext;

  // Control registers plus the one-cycle read-return stage that qualifies operands.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      vl_q     <= '0;
      sew_q    <= '0;
      err_q    <= 1'b0;
      op_vld_q <= 1'b0;
      op_idx_q <= '0;
`ifdef VMUL_CTRL_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      vl_q     <= vl_d;
      sew_q    <= sew_d;
      err_q    <= err_d;
      op_vld_q <= rd_en;
      op_idx_q <= rd_addr;
`ifdef VMUL_CTRL_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  // Next state and control outputs; zero-length or illegal-width jobs go straight to FIN.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    vl_d       = vl_q;
    sew_d      = sew_q;
    err_d      = err_q;
`ifdef VMUL_CTRL_MASK_EN
    mask_d     = mask_q;
`endif
    rd_en      = 1'b0;
    rd_addr    = '0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != ST_IDLE);
    mul_is_mul = 1'b0;
    mul_sew    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mul_is_mul = 1'b1;
          mul_sew    = sew;
          vl_d       = vl;
          sew_d      = sew;
          n_d        = word_count(8'(vl), sew[1:0]);
          err_d      = !sew_legal(sew);
          idx_d      = '0;
`ifdef VMUL_CTRL_MASK_EN
          mask_d     = mask;
`endif
          if (sew_legal(sew) && (vl != '0)) state_d = ST_ISSUE;
          else                              state_d = ST_FIN;
        end
      end
      ST_ISSUE: begin
        mul_is_mul = 1'b1;
        mul_sew    = sew_q;
        rd_en      = 1'b1;
        rd_addr    = idx_q;
        idx_d      = idx_q + AW'(1);
        if (8'(idx_q) == n_q - 8'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        mul_is_mul = 1'b1;
        mul_sew    = sew_q;
        if (pipe_vld && (8'(pipe_idx) == n_q - 8'd1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        mul_is_mul = 1'b1;
        mul_sew    = sew_q;
        done       = 1'b1;
        err        = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  v_mul_ctrl_pipe #(
    .MUL_LAT (MUL_LAT),
    .AW      (AW)
  ) u_pipe (
    .clk       (clk),
    .nrst      (nrst),
    .in_vld_i  (op_vld_q),
    .in_idx_i  (op_idx_q),
    .out_vld_o (pipe_vld),
    .out_idx_o (pipe_idx)
  );

  // Byte enables for the word leaving the pipe: bytes of elements past vl (or masked off) stay untouched.
  always_comb begin
    be_raw   = '0;
    byte_pos = '0;
    elem     = '0;
    vl_ext   = {1'b0, vl_q};
    for (int j = 0; j < 4; j++) begin
      byte_pos  = {pipe_idx, 2'(j)};
      elem      = byte_pos >> sew_q[1:0];
      be_raw[j] = (elem < vl_ext);
`ifdef VMUL_CTRL_MASK_EN
      be_raw[j] = be_raw[j] & mask_q[elem[AW-1:0]];
`endif
    end
  end

  // Operands pass straight through only in the cycle the read data returns; writes mirror the pipe head.
  always_comb begin
    mul_op_a = op_vld_q ? rd_data_a : '0;
    mul_op_b = op_vld_q ? rd_data_b : '0;
    wr_en    = pipe_vld;
    wr_addr  = pipe_vld ? pipe_idx   : '0;
    wr_data  = pipe_vld ? mul_result : '0;
    wr_be    = pipe_vld ? be_raw     : '0;
  end

endmodule

// File: tb/tb_v_mul_ctrl.sv
// Self-checking bench for v_mul_ctrl with register-file and multiplier models.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_v_mul_ctrl;

  localparam int MUL_LAT = 4;
  localparam int MAX_VL  = 32;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  vl = '0;
  logic [2:0]  sew = '0;
  logic [31:0] mask = '0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data_a = '0;
  logic [31:0] rd_data_b = '0;
  logic [31:0] mul_op_a, mul_op_b;
  logic [2:0]  mul_sew;
  logic        mul_is_mul;
  logic [31:0] mul_result = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_s = 0;
  int opz_bad = 0;
  int sew_bad = 0;
  logic [2:0]  exp_sew = '0;
  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];
  logic [31:0] mpipe [MUL_LAT];
  logic        prev_rd = 1'b0;
  int          prev_addr = 0;

  int          rd_cyc_q[$], rd_addr_q[$], wr_cyc_q[$], wr_addr_q[$], wr_be_q[$];
  logic [31:0] wr_dat_q[$];
  int          done_cyc_q[$], done_err_q[$];

  v_mul_ctrl #(.MUL_LAT(MUL_LAT), .MAX_VL(MAX_VL)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .vl         (vl),
    .sew        (sew),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .mul_op_a   (mul_op_a),
    .mul_op_b   (mul_op_b),
    .mul_sew    (mul_sew),
    .mul_is_mul (mul_is_mul),
    .mul_result (mul_result),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
`ifdef VMUL_CTRL_MASK_EN
    .mask       (mask),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Lane-wise signed multiply keeping the low bits of each lane product.
  function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b, input int s);
    logic [31:0] r;
    longint p;
    r = '0;
    case (s)
      0: for (int l = 0; l < 4; l++) begin
           p = longint'($signed(a[8*l +: 8])) * longint'($signed(b[8*l +: 8]));
           r[8*l +: 8] = 8'(p);
         end
      1: for (int l = 0; l < 2; l++) begin
           p = longint'($signed(a[16*l +: 16])) * longint'($signed(b[16*l +: 16]));
           r[16*l +: 16] = 16'(p);
         end
      2: begin
           p = longint'($signed(a)) * longint'($signed(b));
           r = 32'(p);
         end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: multiplier delay line and register file (data one cycle after the read).
  always @(posedge clk) begin
    for (int k = MUL_LAT - 1; k > 0; k--) mpipe[k] = mpipe[k-1];
    mpipe[0]   = lane_mul(mul_op_a, mul_op_b, int'(mul_sew));
    mul_result = mpipe[MUL_LAT-1];
    if (rd_en === 1'b1) begin
      rd_data_a = rf_a[rd_addr];
      rd_data_b = rf_b[rd_addr];
    end else begin
      rd_data_a = $urandom;
      rd_data_b = $urandom;
    end
    cyc++;
  end

  // Monitor: log every access away from the clock edge.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(int'(rd_addr)); end
    if (wr_en === 1'b1) begin
      wr_cyc_q.push_back(cyc); wr_addr_q.push_back(int'(wr_addr));
      wr_be_q.push_back(int'(wr_be)); wr_dat_q.push_back(wr_data);
    end
    if (done === 1'b1) begin done_cyc_q.push_back(cyc); done_err_q.push_back(int'(err)); end
    if (prev_rd) begin
      if (mul_op_a !== rf_a[prev_addr] || mul_op_b !== rf_b[prev_addr]) opz_bad++;
    end else if (mul_op_a !== 32'h0 || mul_op_b !== 32'h0) opz_bad++;
    if (busy === 1'b1) begin
      if (mul_is_mul !== 1'b1 || mul_sew !== exp_sew) sew_bad++;
    end else if (start === 1'b1) begin
      if (mul_is_mul !== 1'b1 || mul_sew !== sew) sew_bad++;
    end else if (mul_is_mul !== 1'b0 || mul_sew !== 3'b000) sew_bad++;
    prev_rd   = (rd_en === 1'b1);
    prev_addr = int'(rd_addr);
  end

  task automatic clear_logs();
    rd_cyc_q.delete(); rd_addr_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    wr_be_q.delete(); wr_dat_q.delete(); done_cyc_q.delete(); done_err_q.delete();
    opz_bad = 0;
    sew_bad = 0;
  endtask

  task automatic run_op(input int vl_v, input int sew_v, input logic [31:0] mask_v, input bit dbl);
    int n, waited, e;
    bit bad;
    logic [3:0] be_e;
    for (int k = 0; k < 32; k++) begin rf_a[k] = $urandom; rf_b[k] = $urandom; end
    clear_logs();
    bad = (sew_v > 2);
    n = (bad || vl_v == 0) ? 0 : ((vl_v << sew_v) + 3) / 4;
    exp_sew = 3'(sew_v);
    @(posedge clk); #1;
    start = 1'b1; vl = 6'(vl_v); sew = 3'(sew_v); mask = mask_v; last_s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (dbl && n > 0) begin
      start = 1'b1; vl = 6'($urandom_range(1, 32)); sew = 3'($urandom_range(0, 2)); mask = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
    end
    waited = 0;
    while (done_cyc_q.size() == 0 && waited < 400) begin @(posedge clk); #1; waited++; end
    repeat (MUL_LAT + 4) begin @(posedge clk); #1; end
    check("done_count", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) begin
      check("done_cyc", done_cyc_q[0] - last_s, (n == 0) ? 1 : 2 + MUL_LAT + n);
      check("done_err", done_err_q[0], bad);
    end
    check("rd_count", rd_cyc_q.size(), n);
    for (int k = 0; k < rd_cyc_q.size() && k < n; k++) begin
      check("rd_cyc", rd_cyc_q[k] - last_s, 1 + k);
      check("rd_addr", rd_addr_q[k], k);
    end
    check("wr_count", wr_cyc_q.size(), n);
    for (int k = 0; k < wr_cyc_q.size() && k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        e = (4 * k + j) >> sew_v;
        be_e[j] = (e < vl_v);
`ifdef VMUL_CTRL_MASK_EN
        if (e < 32) be_e[j] = be_e[j] & mask_v[e];
`endif
      end
      check("wr_cyc", wr_cyc_q[k] - last_s, 2 + MUL_LAT + k);
      check("wr_addr", wr_addr_q[k], k);
      check("wr_be", wr_be_q[k], be_e);
      check("wr_data", wr_dat_q[k], lane_mul(rf_a[k], rf_b[k], sew_v));
    end
    check("op_gate", opz_bad, 0);
    check("mul_sew_hold", sew_bad, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int wcount;
    for (int k = 0; k < MUL_LAT; k++) mpipe[k] = '0;
    for (int k = 0; k < 32; k++) begin rf_a[k] = '0; rf_b[k] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_is_mul", mul_is_mul, 0);
    check("rst_mul_sew", mul_sew, 0);
    check("rst_wr_be", wr_be, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Basic 32-bit op, fixed timing.
    run_op(4, 2, 32'hFFFF_FFFF, 1'b0);
    if (done_cyc_q.size() > 0) check("d32_done_at", done_cyc_q[0] - last_s, 10);
    for (int k = 0; k < wr_be_q.size(); k++) check("d32_be", wr_be_q[k], 4'hF);

    // 8-bit op with a tail word.
    run_op(5, 0, 32'hFFFF_FFFF, 1'b0);
    if (wr_be_q.size() >= 2) begin
      check("d8_be0", wr_be_q[0], 4'hF);
      check("d8_be1", wr_be_q[1], 4'h1);
    end

    // Empty and illegal-width jobs.
    run_op(0, 1, 32'hFFFF_FFFF, 1'b0);
    run_op(3, 3, 32'hFFFF_FFFF, 1'b0);

`ifdef VMUL_CTRL_MASK_EN
    run_op(4, 1, 32'h0000_0005, 1'b0);
    if (wr_be_q.size() >= 2) begin
      check("mask_be0", wr_be_q[0], 4'h3);
      check("mask_be1", wr_be_q[1], 4'h3);
    end
`endif

    // Start pulsed while busy must not disturb the running job.
    run_op(6, 1, 32'hFFFF_FFFF, 1'b1);

    // Reset during DRAIN drops pending writes.
    for (int k = 0; k < 32; k++) begin rf_a[k] = $urandom; rf_b[k] = $urandom; end
    clear_logs();
    exp_sew = 3'd1;
    @(posedge clk); #1;
    start = 1'b1; vl = 6'd8; sew = 3'd1; mask = '1; last_s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < last_s + 6) begin @(posedge clk); #1; end
    nrst = 1'b0;
    @(posedge clk); #1;
    wcount = wr_cyc_q.size();
    check("rst_mid_writes", wcount, 1);
    @(negedge clk);
    check("rstm_busy", busy, 0);
    check("rstm_wr_en", wr_en, 0);
    check("rstm_rd_en", rd_en, 0);
    check("rstm_wr_data", wr_data, 0);
    check("rstm_op_a", mul_op_a, 0);
    check("rstm_is_mul", mul_is_mul, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("rstm_no_wr", wr_cyc_q.size(), wcount);
    run_op(8, 1, 32'hFFFF_FFFF, 1'b0);

    // Randomized jobs.
    for (int t = 0; t < 20; t++) begin
      int sv;
      sv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
      run_op(int'($urandom_range(0, 32)), sv, $urandom, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
